muldiv_seq: RTL and testbench

- Iterative multiply/divide sequencer with architectural HI/LO registers for the MIPS32 pipeline.
- Executes MULT, MULTU, DIV and DIVU over a fixed 34-cycle sequence, using shift-add for multiply and restoring division for divide.
- Drives `busy` into the hazard unit, which stalls MFHI/MFLO and any further mul/div until the result is written.
- Sits beside the ALU in EX. The ALU keeps single-cycle ops; this block owns HI/LO.

---
 rtl/muldiv_seq_if.sv | 17 +
 rtl/muldiv_seq.sv | 79 +++++++
 tb/tb_muldiv_seq.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: issue, MTHI/MTLO, flush and result bundle of the HI/LO multiply/divide unit
interface muldiv_seq_if #(parameter int WIDTH = 32);
  logic start;
  logic [1:0] op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic hi_we;
  logic lo_we;
  logic [WIDTH-1:0] wdata;
  logic flush;
  logic busy;
  logic done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master(output start, op, a, b, hi_we, lo_we, wdata, flush, input busy, done, hi, lo);
  modport slave(input start, op, a, b, hi_we, lo_we, wdata, flush, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers
module muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic clk,
  input logic reset,
  muldiv_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] ma, mb, hi_r, lo_r, quo, rem;
  logic [2*WIDTH-1:0] acc, prod;
  logic [1:0] op_r;
  logic sign_a, sign_b, done_r, go, last;
  logic [WIDTH:0] msum, rtry;
  logic [WIDTH+1:0] diff;
  always_comb begin
    go = state == IDLE && bus.start && !bus.flush;
    last = cnt == CNT_W'(WIDTH - 1);
    state_n = state == IDLE ? (go ? ITER : IDLE) :
              bus.flush ? IDLE :
              state == ITER ? (last ? FIX : ITER) : IDLE;
    msum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, ma & {WIDTH{mb[0]}}};
    rtry = {acc[2*WIDTH-1:WIDTH], ma[WIDTH-1]};
    diff = {1'b0, rtry} - {2'b0, mb};
    prod = (sign_a ^ sign_b) ? -acc : acc;
    // a zero divisor leaves |a| as remainder, so the sign fix restores raw a in HI
    quo = mb == '0 ? '1 : (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      ma <= '0;
      mb <= '0;
      acc <= '0;
      op_r <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      hi_r <= '0;
      lo_r <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (go) begin
        sign_a <= !bus.op[0] && bus.a[WIDTH-1];
        sign_b <= !bus.op[0] && bus.b[WIDTH-1];
        ma <= (!bus.op[0] && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        mb <= (!bus.op[0] && bus.b[WIDTH-1]) ? -bus.b : bus.b;
        op_r <= bus.op;
        acc <= '0;
        cnt <= '0;
      end else if (state == IDLE) begin
        if (bus.hi_we && !bus.start) hi_r <= bus.wdata;
        if (bus.lo_we && !bus.start) lo_r <= bus.wdata;
      end else if (state == ITER) begin
        cnt <= cnt + 1'b1;
        if (op_r[1]) begin
          acc <= {diff[WIDTH+1] ? rtry[WIDTH-1:0] : diff[WIDTH-1:0], acc[WIDTH-2:0], !diff[WIDTH+1]};
          ma <= ma << 1;
        end else begin
          acc <= {msum, acc[WIDTH-1:1]};
          mb <= mb >> 1;
        end
      end else if (!bus.flush) begin
        {hi_r, lo_r} <= op_r[1] ? {rem, quo} : prod;
        done_r <= 1'b1;
      end
    end
  assign bus.busy = state != IDLE;
  assign bus.done = done_r;
  assign bus.hi = hi_r;
  assign bus.lo = lo_r;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: scoreboard bench for muldiv_seq against a plain-arithmetic HI/LO model
module tb_muldiv_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int vectors = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  muldiv_seq_if #(.WIDTH(32)) bus();
  muldiv_seq #(.WIDTH(32), .CNT_W(6)) dut(.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, want);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic s;
    int sx, sy;
    s = !o[0];
    sx = x;
    sy = y;
    if (!o[1]) return {{32{s & x[31]}}, x} * {{32{s & y[31]}}, y};
    if (y == 0) return {x, 32'hFFFFFFFF};
    if (o[0]) return {x % y, x / y};
    if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
    return {32'(sx % sy), 32'(sx / sy)};
  endfunction

  always @(negedge clk)
    if (!reset && bus.done) begin
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_done hi=%h lo=%h expected no result", bus.hi, bus.lo);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("result_hi", bus.hi, e[63:32]);
        chk("result_lo", bus.lo, e[31:0]);
      end
    end

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [63:0] want, input bit mtlo, input bit disturb);
    int busy_cyc = 0;
    int k = 0;
    bus.op = o;
    bus.a = x;
    bus.b = y;
    bus.start = 1'b1;
    bus.lo_we = mtlo;
    bus.wdata = 32'h0;
    exp_q.push_back(want);
    @(posedge clk);
    #1 bus.start = 1'b0;
    bus.lo_we = 1'b0;
    do begin
      @(negedge clk);
      k++;
      if (bus.busy) busy_cyc++;
      if (mtlo && k == 1) chk("mtlo_dropped", bus.lo, 32'hA5A5A5A5);
      if (disturb && k == 10) begin
        bus.start = 1'b1;
        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wdata = 32'hDEADBEEF;
        bus.op = 2'b10;
        bus.a = 32'h12345678;
        bus.b = 32'h9;
      end
      if (disturb && k == 12) begin
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
      end
    end while (!bus.done && k < 100);
    chk("busy_cycles", busy_cyc, 33);
    chk("done_cycle", k, 34);
    @(negedge clk);
    chk("done_pulse", {31'b0, bus.done}, 32'h0);
    @(posedge clk);
    #1;
  endtask

  task automatic mt(input bit hw, input bit lw, input logic [31:0] d);
    bus.hi_we = hw;
    bus.lo_we = lw;
    bus.wdata = d;
    @(posedge clk);
    #1 bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
  endtask

  initial begin
    logic [1:0] o;
    logic [31:0] x, y;
    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.a = '0;
    bus.b = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    bus.flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hi", bus.hi, 32'h0);
    chk("reset_lo", bus.lo, 32'h0);
    chk("reset_busy_done", {30'b0, bus.busy, bus.done}, 32'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    run_op(2'b00, 32'hFFFFFFFF, 32'h3, {32'hFFFFFFFF, 32'hFFFFFFFD}, 0, 0);
    run_op(2'b01, 32'hFFFFFFFF, 32'h3, {32'h00000002, 32'hFFFFFFFD}, 0, 0);
    run_op(2'b10, 32'hFFFFFFF9, 32'h2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 0, 0);
    run_op(2'b11, 32'h7, 32'h2, {32'h1, 32'h3}, 0, 0);
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 0, 0);
    run_op(2'b10, 32'h80000000, 32'h0, {32'h80000000, 32'hFFFFFFFF}, 0, 0);
    run_op(2'b11, 32'h5, 32'h0, {32'h5, 32'hFFFFFFFF}, 0, 0);
    run_op(2'b10, 32'hFFFFFFF9, 32'h0, {32'hFFFFFFF9, 32'hFFFFFFFF}, 0, 0);
    run_op(2'b10, 32'h7, 32'hFFFFFFFE, {32'h1, 32'hFFFFFFFD}, 0, 0);
    mt(1, 0, 32'h11);
    mt(0, 1, 32'h22);
    chk("mthi", bus.hi, 32'h11);
    chk("mtlo", bus.lo, 32'h22);
    // flush mid-run: no write-back, no done
    bus.op = 2'b01;
    bus.a = 32'd5;
    bus.b = 32'd6;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    chk("flush_busy", {31'b0, bus.busy}, 32'h0);
    repeat (40) @(posedge clk);
    #1;
    chk("flush_hi", bus.hi, 32'h11);
    chk("flush_lo", bus.lo, 32'h22);
    bus.start = 1'b1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    bus.flush = 1'b0;
    chk("flush_start_dropped", {31'b0, bus.busy}, 32'h0);
    run_op(2'b01, 32'd5, 32'd6, {32'h0, 32'd30}, 0, 1);
    mt(1, 1, 32'h1234);
    // async reset in the middle of a MULT
    bus.op = 2'b00;
    bus.a = 32'hFFFFFFF0;
    bus.b = 32'h7;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (19) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("async_reset_hi", bus.hi, 32'h0);
    chk("async_reset_lo", bus.lo, 32'h0);
    chk("async_reset_busy_done", {30'b0, bus.busy, bus.done}, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    run_op(2'b01, 32'd2, 32'd2, {32'h0, 32'd4}, 0, 0);
    mt(1, 1, 32'hA5A5A5A5);
    chk("mt_both_hi", bus.hi, 32'hA5A5A5A5);
    chk("mt_both_lo", bus.lo, 32'hA5A5A5A5);
    run_op(2'b01, 32'd1, 32'd1, {32'h0, 32'd1}, 1, 0);
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'h0;
        1: y = 32'($urandom_range(1, 15));
        2: begin x = 32'h80000000; y = 32'hFFFFFFFF; end
        3: x = 32'($urandom_range(0, 100));
        default: ;
      endcase
      run_op(o, x, y, model(o, x, y), 0, 0);
    end
    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      vectors++;
      errors++;
      $display("FAIL pending_results got=%0d expected=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
